register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//   Parametrised multi-port register file: DEPTH x WIDTH storage, one synchronous write port, READ_PORTS
//   asynchronous read ports, optional hard-wired zero entry and optional write-to-read bypass.
//   Generalises the single Register to an addressable array; serves as the MIPS GPR file ($0..$31)
//   between decode (reads rs/rt) and writeback (writes rd/rt).
// PARAMETERS
//   WIDTH      32  bits per entry
//   DEPTH      32  number of entries (>=2; need not be power of two)
//   READ_PORTS 2   number of independent read ports (>=1)
//   ZERO_REG   1   1: entry 0 always reads 0, writes to it discarded; 0: entry 0 is ordinary storage
//   BYPASS     1   1: same-cycle write data forwarded to matching read ports; 0: reads show stored value only
//   ADDR_W     derived localparam = $clog2(DEPTH), not overridable
// PORTS
//   clk      in   1                  rising-edge clock
//   reset    in   1                  asynchronous, active-high; clears every entry
//   wr_en    in   1                  write request this cycle
//   wr_addr  in   ADDR_W             write index
//   wr_data  in   WIDTH              write value
//   rd_addr  in   READ_PORTS*ADDR_W  read index, port p in bits [p*ADDR_W +: ADDR_W]
//   rd_data  out  READ_PORTS*WIDTH   read value, port p in bits [p*WIDTH +: WIDTH]
// BEHAVIOUR
//   Reset: on reset rising (no clock needed) every entry <= 0; held while reset=1; all rd_data = 0
//     while reset=1 (bypass suppressed). Writes presented during reset are discarded.
//   Write: at posedge clk with reset=0 and wr_en=1, mem[wr_addr] <= wr_data; visible in storage next cycle.
//     Discarded if wr_addr >= DEPTH, or ZERO_REG=1 and wr_addr==0. wr_en=0: no entry changes.
//   Read: combinational, zero latency; each port independent; any ports may share an address.
//     rd_data[p] = 0 if rd_addr[p] >= DEPTH, or ZERO_REG=1 and rd_addr[p]==0.
//     Else, if BYPASS=1 and wr_en=1 and wr_addr==rd_addr[p] and the write is not discarded: wr_data.
//     Else mem[rd_addr[p]].
//   Priority per port: reset > out-of-range/zero-reg > bypass > stored value.
//   BYPASS=0 with same-address read/write: read returns old value this cycle, new value from next cycle.
//   Single write port; no write conflicts exist. No X ever driven on rd_data after reset seen.
//   Reset mid-operation: a write whose posedge coincides with reset=1 is lost; storage = 0 after release.
//   First write allowed on the first posedge after reset falls.
//   Implementation: storage is a register array (per-entry Register instances or equivalent always_ff);
//     read muxes and bypass compares generated per port with a generate loop.
// TESTING
//   1 Reset: write 0xDEADBEEF to all 32 entries, assert reset mid-cycle -> all rd_data 0 immediately, every entry reads 0 after release.
//   2 Write/read: write 0x12345678 to 5, 0xCAFEF00D to 31; port0=5, port1=31 next cycle -> 0x12345678, 0xCAFEF00D.
//   3 Zero reg: ZERO_REG=1, write 0xFFFFFFFF to 0 -> reads 0; ZERO_REG=0 same stimulus -> reads 0xFFFFFFFF.
//   4 Bypass: mem[7]=0x1, same cycle wr_en=1 addr 7 data 0x2, port0=7 -> BYPASS=1 gives 0x2; BYPASS=0 gives 0x1 then 0x2 next cycle.
//   5 Range/ports: DEPTH=24, READ_PORTS=3; write addr 30 -> no entry changes, read 30 -> 0; all 3 ports on addr 9 -> identical values.
//   6 Random: 10k cycles random wr_en/addr/data/rd_addr with sporadic async reset vs. behavioural array model -> zero mismatches.

Source files
------------

// File: rtl/register_file_if.sv
// Register file access bus: one write port plus READ_PORTS packed read ports.
interface register_file_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned READ_PORTS = 2
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic                         wr_en;
  logic [ADDR_W-1:0]            wr_addr;
  logic [WIDTH-1:0]             wr_data;
  logic [READ_PORTS*ADDR_W-1:0] rd_addr;
  logic [READ_PORTS*WIDTH-1:0]  rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr,
    output rd_data
  );
endinterface

// File: rtl/register_file.sv
// DEPTH x WIDTH register file: one synchronous write port, READ_PORTS
// combinational read ports, optional hard-wired zero entry and write bypass.
module register_file #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned READ_PORTS = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic           clk,
  input  logic           reset,
  register_file_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]                  mem_q [DEPTH];
  logic                              wr_ok;
  logic [READ_PORTS-1:0][WIDTH-1:0]  rd_val;

  // A write is effective only in range and not aimed at the hard-wired zero entry.
  assign wr_ok = bus.wr_en
              && (32'(bus.wr_addr) < DEPTH)
              && !((ZERO_REG != 0) && (bus.wr_addr == '0));

  // Storage array: cleared asynchronously, written on the rising clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else if (wr_ok) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_safe;
    logic              in_range;
    logic              is_zero;
    logic              hit;

    assign addr      = bus.rd_addr[p*ADDR_W +: ADDR_W];
    assign in_range  = (32'(addr) < DEPTH);
    // Out-of-range reads never index the array, so no X can leak out.
    assign addr_safe = in_range ? addr : '0;
    assign is_zero   = (ZERO_REG != 0) && (addr == '0);
    assign hit       = (BYPASS != 0) && wr_ok && (bus.wr_addr == addr);

    // Read priority: reset, then out-of-range/zero entry, then bypass, then storage.
    assign rd_val[p] = reset                 ? '0 :
                       (!in_range || is_zero) ? '0 :
                       hit                   ? bus.wr_data :
                                               mem_q[addr_safe];
  end

  assign bus.rd_data = rd_val;
endmodule

// File: tb/tb_register_file.sv
// Scoreboarded bench for register_file: three configurations share one write
// stream; expectations are queued by the stimulus and checked at negedge.
module tb_register_file;
  typedef struct {
    string       name;
    int          dut;
    int          port;
    logic [31:0] exp;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  ra_a;
  logic [9:0]  ra_b;
  logic [14:0] ra_c;

  sb_item_t    sb[$];
  logic [31:0] model_a [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  register_file_if #(.WIDTH(32), .DEPTH(32), .READ_PORTS(2)) ifa ();
  register_file_if #(.WIDTH(32), .DEPTH(32), .READ_PORTS(2)) ifb ();
  register_file_if #(.WIDTH(32), .DEPTH(24), .READ_PORTS(3)) ifc ();

  assign ifa.wr_en = wr_en;  assign ifa.wr_addr = wr_addr;  assign ifa.wr_data = wr_data;
  assign ifb.wr_en = wr_en;  assign ifb.wr_addr = wr_addr;  assign ifb.wr_data = wr_data;
  assign ifc.wr_en = wr_en;  assign ifc.wr_addr = wr_addr;  assign ifc.wr_data = wr_data;
  assign ifa.rd_addr = ra_a;
  assign ifb.rd_addr = ra_b;
  assign ifc.rd_addr = ra_c;

  register_file #(.WIDTH(32), .DEPTH(32), .READ_PORTS(2), .ZERO_REG(1), .BYPASS(1))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  register_file #(.WIDTH(32), .DEPTH(32), .READ_PORTS(2), .ZERO_REG(0), .BYPASS(0))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));
  register_file #(.WIDTH(32), .DEPTH(24), .READ_PORTS(3), .ZERO_REG(1), .BYPASS(1))
    dut_c (.clk(clk), .reset(reset), .bus(ifc));

  function automatic logic [31:0] get_rd(input int d, input int p);
    case (d)
      0:       return ifa.rd_data[p*32 +: 32];
      1:       return ifb.rd_data[p*32 +: 32];
      default: return ifc.rd_data[p*32 +: 32];
    endcase
  endfunction

  // Expected read of configuration A (zero entry, bypass) from the array model.
  function automatic logic [31:0] model_rd(input logic [4:0] ra);
    if (reset) return 32'h0;
    if (ra == 5'd0) return 32'h0;
    if (wr_en && (wr_addr == ra)) return wr_data;
    return model_a[ra];
  endfunction

  task automatic exp_push(input string nm, input int d, input int p, input logic [31:0] e);
    sb.push_back('{name: nm, dut: d, port: p, exp: e});
  endtask

  task automatic set_ra(input int d, input int p, input int a);
    case (d)
      0:       ra_a[p*5 +: 5] = 5'(a);
      1:       ra_b[p*5 +: 5] = 5'(a);
      default: ra_c[p*5 +: 5] = 5'(a);
    endcase
  endtask

  task automatic wr(input logic en, input int a, input logic [31:0] d);
    wr_en   = en;
    wr_addr = 5'(a);
    wr_data = d;
  endtask

  // Advance one clock; the model commits the write the DUT saw at this edge.
  task automatic step();
    @(posedge clk);
    if (!reset && wr_en && (wr_addr != 5'd0)) model_a[wr_addr] = wr_data;
    #1;
  endtask

  // Monitor: drain all expectations queued for this cycle at the falling edge.
  initial begin
    sb_item_t    it;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        it  = sb.pop_front();
        act = get_rd(it.dut, it.port);
        n_tests++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: dut%0d port%0d got %h expected %h",
                   it.name, it.dut, it.port, act, it.exp);
        end
      end
    end
  end

  // Watchdog against a stuck run.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    wr(1'b0, 0, 32'h0);
    ra_a = '0; ra_b = '0; ra_c = '0;
    model_a = '{default: '0};

    // Reset held: reads forced to zero.
    set_ra(0, 0, 5); set_ra(0, 1, 31);
    step(); step();
    exp_push("rst_hold", 0, 0, 32'h0);
    exp_push("rst_hold", 0, 1, 32'h0);
    step();
    reset = 1'b0;
    exp_push("post_rst", 0, 0, 32'h0);

    // Fill everything, then pulse reset between clock edges.
    for (int i = 0; i < 32; i++) begin
      wr(1'b1, i, 32'hDEADBEEF);
      step();
    end
    wr_en = 1'b0;
    set_ra(1, 0, 0);
    exp_push("fill", 0, 0, 32'hDEADBEEF);
    exp_push("fill", 0, 1, 32'hDEADBEEF);
    exp_push("fill_b0", 1, 0, 32'hDEADBEEF);
    step();
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    model_a = '{default: '0};
    exp_push("async_clr", 0, 0, 32'h0);
    exp_push("async_clr", 0, 1, 32'h0);
    exp_push("async_clr_b0", 1, 0, 32'h0);
    step();
    for (int i = 0; i < 32; i += 2) begin
      set_ra(0, 0, i); set_ra(0, 1, i + 1);
      exp_push("clr_all", 0, 0, 32'h0);
      exp_push("clr_all", 0, 1, 32'h0);
      step();
    end

    // Basic write then read.
    wr(1'b1, 5, 32'h12345678);  step();
    wr(1'b1, 31, 32'hCAFEF00D); step();
    wr_en = 1'b0;
    set_ra(0, 0, 5); set_ra(0, 1, 31);
    exp_push("wr_rd5", 0, 0, 32'h12345678);
    exp_push("wr_rd31", 0, 1, 32'hCAFEF00D);
    step();

    // Zero entry vs. ordinary entry 0.
    wr(1'b1, 0, 32'hFFFFFFFF);
    set_ra(0, 0, 0); set_ra(1, 0, 0);
    exp_push("zero_byp", 0, 0, 32'h0);
    exp_push("nobyp_old0", 1, 0, 32'h0);
    step();
    wr_en = 1'b0;
    exp_push("zero_reg", 0, 0, 32'h0);
    exp_push("plain_reg0", 1, 0, 32'hFFFFFFFF);
    step();

    // Bypass vs. no bypass on a same-cycle write.
    wr(1'b1, 7, 32'h1); step();
    wr(1'b1, 7, 32'h2);
    set_ra(0, 0, 7); set_ra(1, 0, 7);
    exp_push("bypass_on", 0, 0, 32'h2);
    exp_push("bypass_off", 1, 0, 32'h1);
    step();
    wr_en = 1'b0;
    exp_push("bypass_on_next", 0, 0, 32'h2);
    exp_push("bypass_off_next", 1, 0, 32'h2);
    step();

    // Range and multi-port on DEPTH=24, READ_PORTS=3.
    wr(1'b1, 9, 32'h99);  step();
    wr(1'b1, 23, 32'h23); step();
    wr(1'b1, 30, 32'hAAAA5555);
    for (int p = 0; p < 3; p++) begin
      set_ra(2, p, 30);
      exp_push("oor_byp", 2, p, 32'h0);
    end
    step();
    wr_en = 1'b0;
    for (int p = 0; p < 3; p++) begin
      set_ra(2, p, 9);
      exp_push("same_addr", 2, p, 32'h99);
    end
    step();
    set_ra(2, 0, 6); set_ra(2, 1, 30); set_ra(2, 2, 23);
    exp_push("no_alias6", 2, 0, 32'h0);
    exp_push("oor_read", 2, 1, 32'h0);
    exp_push("last_entry", 2, 2, 32'h23);
    step();

    // Random traffic with sporadic async reset against the array model.
    for (int c = 0; c < 10000; c++) begin
      if (reset) begin
        if ($urandom_range(3) == 0) reset = 1'b0;
      end else if ($urandom_range(199) == 0) begin
        reset = 1'b1;
        model_a = '{default: '0};
      end
      wr(1'($urandom_range(1)), int'($urandom_range(31)), $urandom);
      set_ra(0, 0, int'($urandom_range(31)));
      set_ra(0, 1, int'($urandom_range(31)));
      exp_push("random", 0, 0, model_rd(ra_a[4:0]));
      exp_push("random", 0, 1, model_rd(ra_a[9:5]));
      step();
    end

    reset = 1'b0;
    wr_en = 1'b0;
    step(); step();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
